// File: rtl/fpmult_norm_round_pipe_pkg.sv
// Shared FPMult constants, stage payload types and exception bit positions (fp16 layout).
package fpmult_norm_round_pipe_pkg;
  localparam int EXPONENT = 5;
  localparam int MANTISSA = 10;
  localparam int SPLIT    = 9;
  localparam int BIAS     = 2**(EXPONENT-1) - 1;
  localparam int DWIDTH   = 1 + EXPONENT + MANTISSA;
  localparam int PWIDTH   = 2*MANTISSA + 2;
  localparam int EWIDTH   = EXPONENT + 2;
  localparam int EMAX     = 2**EXPONENT - 1;

  localparam logic [DWIDTH-1:0] QNAN = {1'b0, {EXPONENT{1'b1}}, 1'b1, {(MANTISSA-1){1'b0}}};

  // out_exc = {overflow, underflow, inexact, invalid}
  localparam int EXC_OVERFLOW  = 3;
  localparam int EXC_UNDERFLOW = 2;
  localparam int EXC_INEXACT   = 1;
  localparam int EXC_INVALID   = 0;

  // InputExc = {any, ANaN, BNaN, AInf, BInf}
  localparam int IEXC_ANY  = 4;
  localparam int IEXC_ANAN = 3;
  localparam int IEXC_BNAN = 2;
  localparam int IEXC_AINF = 1;
  localparam int IEXC_BINF = 0;

  typedef struct packed {
    logic              sign;
    logic [EWIDTH-1:0] expo;
    logic              zero;
    logic [4:0]        exc;
  } hdr_t;

  typedef struct packed {
    logic [MANTISSA-1:0] frac;
    logic                guard;
    logic                sticky;
  } norm_t;

  function automatic logic [DWIDTH-1:0] pack_fp(input logic s,
                                                input logic [EXPONENT-1:0] e,
                                                input logic [MANTISSA-1:0] m);
    return {s, e, m};
  endfunction
endpackage

// File: rtl/fpmult_round_pack.sv
// Final multiply stage: rounding, range check, exception override and IEEE packing.
// FPMULT_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise truncation toward zero.
module fpmult_round_pack
  import fpmult_norm_round_pipe_pkg::*;
(
  input  hdr_t              hdr,
  input  norm_t             norm,
  output logic [DWIDTH-1:0] result,
  output logic [3:0]        exc
);
  logic [MANTISSA-1:0] mant;
  logic [EWIDTH-1:0]   exp_r;
  logic                inexact;
  logic                overflow;
  logic                underflow;
  logic                any_inf;
  logic                is_nan;
  logic                is_inf;

`ifdef FPMULT_ROUND_NEAREST_EN
  logic              round_up;
  logic [MANTISSA:0] mant_sum;

  // A carry out of the fraction means 1.111..1 rounded up to 10.000..0.
  assign round_up = norm.guard & (norm.sticky | norm.frac[0]);
  assign mant_sum = {1'b0, norm.frac} + {{MANTISSA{1'b0}}, round_up};
  assign mant     = mant_sum[MANTISSA-1:0];
  assign exp_r    = hdr.expo + {{(EWIDTH-1){1'b0}}, mant_sum[MANTISSA]};
`else
  assign mant  = norm.frac;
  assign exp_r = hdr.expo;
`endif

  assign inexact   = norm.guard | norm.sticky;
  assign overflow  = ~exp_r[EWIDTH-1] & (exp_r >= EWIDTH'(EMAX));
  assign underflow = exp_r[EWIDTH-1] | (exp_r == '0);
  assign any_inf   = hdr.exc[IEXC_AINF] | hdr.exc[IEXC_BINF];
  assign is_nan    = hdr.exc[IEXC_ANY] &
                     (hdr.exc[IEXC_ANAN] | hdr.exc[IEXC_BNAN] | (any_inf & hdr.zero));
  assign is_inf    = hdr.exc[IEXC_ANY] & any_inf;

  always_comb begin
    result = pack_fp(hdr.sign, exp_r[EXPONENT-1:0], mant);
    exc    = '0;
    exc[EXC_INEXACT] = inexact;
    if (is_nan) begin
      result = QNAN;
      exc    = '0;
      exc[EXC_INVALID] = 1'b1;
    end else if (is_inf) begin
      result = pack_fp(hdr.sign, '1, '0);
      exc    = '0;
    end else if (hdr.zero) begin
      // Denormal or zero operand: product flushed to zero without raising anything.
      result = pack_fp(hdr.sign, '0, '0);
      exc    = '0;
    end else if (overflow) begin
      result = pack_fp(hdr.sign, '1, '0);
      exc    = '0;
      exc[EXC_OVERFLOW] = 1'b1;
      exc[EXC_INEXACT]  = 1'b1;
    end else if (underflow) begin
      result = pack_fp(hdr.sign, '0, '0);
      exc    = '0;
      exc[EXC_UNDERFLOW] = 1'b1;
      exc[EXC_INEXACT]   = 1'b1;
    end
  end
endmodule

// File: rtl/fpmult_norm_round_pipe.sv
// FPMult back end: completes the split product, normalizes, rounds and packs in 3 stages.
// Rounding mode set by FPMULT_ROUND_NEAREST_EN (undefined: truncate); valid/ready on both sides.
module fpmult_norm_round_pipe
  import fpmult_norm_round_pipe_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                Sa,
  input  logic                Sb,
  input  logic [EXPONENT-1:0] Ea,
  input  logic [EXPONENT-1:0] Eb,
  input  logic [PWIDTH-1:0]   Mp,
  input  logic [MANTISSA-1:0] Ma,
  input  logic [SPLIT-1:0]    Mb_lo,
  input  logic [4:0]          InputExc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DWIDTH-1:0]   result,
  output logic [3:0]          out_exc
);
  logic v1_reg, v2_reg, v3_reg;
  logic ready1, ready2, ready3;

  logic [PWIDTH-1:0] p_calc;
  hdr_t              hdr_calc;
  logic [PWIDTH-1:0] s1_p_reg;
  hdr_t              s1_hdr_reg;

  hdr_t  hdr_norm;
  norm_t norm_calc;
  hdr_t  s2_hdr_reg;
  norm_t s2_norm_reg;

  logic [DWIDTH-1:0] pack_result;
  logic [3:0]        pack_exc;
  logic [DWIDTH-1:0] result_reg;
  logic [3:0]        exc_reg;

  // A stage may load when it is empty or its content moves on this cycle.
  assign ready3   = ~v3_reg | out_ready;
  assign ready2   = ~v2_reg | ready3;
  assign ready1   = ~v1_reg | ready2;
  assign in_ready = ready1 & ~rst;

  // Stage 1: the prep stage skipped Mb's low SPLIT bits, add their partial product back in.
  assign p_calc = (Mp << SPLIT) + (PWIDTH'({1'b1, Ma}) * PWIDTH'(Mb_lo));

  always_comb begin
    hdr_calc.sign = Sa ^ Sb;
    hdr_calc.expo = EWIDTH'(Ea) + EWIDTH'(Eb) - EWIDTH'(BIAS);
    hdr_calc.zero = (Ea == '0) | (Eb == '0);
    hdr_calc.exc  = InputExc;
  end

  // Stage 2: product of two [1,2) significands lies in [1,4); at most one right shift.
  always_comb begin
    hdr_norm  = s1_hdr_reg;
    norm_calc = '0;
    if (s1_p_reg[PWIDTH-1]) begin
      hdr_norm.expo    = s1_hdr_reg.expo + EWIDTH'(1);
      norm_calc.frac   = s1_p_reg[PWIDTH-2 -: MANTISSA];
      norm_calc.guard  = s1_p_reg[PWIDTH-2-MANTISSA];
      norm_calc.sticky = |s1_p_reg[PWIDTH-3-MANTISSA:0];
    end else begin
      norm_calc.frac   = s1_p_reg[PWIDTH-3 -: MANTISSA];
      norm_calc.guard  = s1_p_reg[PWIDTH-3-MANTISSA];
      norm_calc.sticky = |s1_p_reg[PWIDTH-4-MANTISSA:0];
    end
  end

  fpmult_round_pack u_round_pack (
    .hdr    (s2_hdr_reg),
    .norm   (s2_norm_reg),
    .result (pack_result),
    .exc    (pack_exc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg     <= 1'b0;
      v2_reg     <= 1'b0;
      v3_reg     <= 1'b0;
      result_reg <= '0;
      exc_reg    <= '0;
    end else begin
      if (ready1) v1_reg <= in_valid;
      if (ready2) v2_reg <= v1_reg;
      if (ready3) begin
        v3_reg <= v2_reg;
        if (v2_reg) begin
          result_reg <= pack_result;
          exc_reg    <= pack_exc;
        end
      end
    end
  end

  // Payload registers need no reset: the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (ready1 && in_valid) begin
      s1_p_reg   <= p_calc;
      s1_hdr_reg <= hdr_calc;
    end
    if (ready2 && v1_reg) begin
      s2_hdr_reg  <= hdr_norm;
      s2_norm_reg <= norm_calc;
    end
  end

  assign out_valid = v3_reg;
  assign result    = result_reg;
  assign out_exc   = exc_reg;
endmodule
